// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one single-port RAM between requesters A and B.
// Round-robin arbitration with an optional lock for back-to-back accesses.
// While the other side waits, a lock lasts at most LOCK_MAX grants.
// The grant path is combinational, so a request can be issued in the cycle it is raised.
// Read data returns one cycle after the read strobe and is steered to the side that issued it.
module ram_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_lock,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_lock,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;        // side of the most recent grant: 0=A, 1=B
    logic [CNT_W-1:0] cnt_q, cnt_d;          // locked grants issued while the other side waited
    logic             rd_valid_q, rd_valid_d;
    logic             rd_side_q, rd_side_d;

    logic             gnt_any;
    logic             g_side;
    logic             g_lock;
    logic             g_we;
    logic             other_req;
    logic             own_req;
    logic             own_lock;
    logic             peer_req;
    logic [CNT_W-1:0] cnt_inc;

    // Grant decision: the lock owner only, otherwise round-robin with idle sides skipped.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_ARB: begin
                    if (a_req && b_req) begin
                        a_gnt = last_q;
                        b_gnt = !last_q;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                ST_LOCK_A: a_gnt = a_req;
                ST_LOCK_B: b_gnt = b_req;
                default: begin
                    a_gnt = 1'b0;
                    b_gnt = 1'b0;
                end
            endcase
        end
    end

    // RAM side: steer the winner's access through, drive zeros when idle.
    always_comb begin
        gnt_any   = a_gnt | b_gnt;
        g_side    = b_gnt;
        g_lock    = b_gnt ? b_lock : a_lock;
        g_we      = b_gnt ? b_we : a_we;
        other_req = b_gnt ? a_req : b_req;
        ram_en    = gnt_any;
        ram_we    = gnt_any & g_we;
        ram_addr  = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
        ram_wdata = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);
    end

    // Read return: the tagged side sees the RAM data, the other side sees zero.
    always_comb begin
        a_rvalid = !rst && rd_valid_q && !rd_side_q;
        b_rvalid = !rst && rd_valid_q &&  rd_side_q;
        a_rdata  = a_rvalid ? ram_rdata : '0;
        b_rdata  = b_rvalid ? ram_rdata : '0;
    end

    // Next state: lock entry, release, and the tenure cap while the other side waits.
    always_comb begin
        state_d    = state_q;
        last_d     = gnt_any ? g_side : last_q;
        cnt_d      = cnt_q;
        rd_valid_d = gnt_any && !g_we;
        rd_side_d  = gnt_any ? g_side : rd_side_q;
        own_req    = (state_q == ST_LOCK_B) ? b_req  : a_req;
        own_lock   = (state_q == ST_LOCK_B) ? b_lock : a_lock;
        peer_req   = (state_q == ST_LOCK_B) ? a_req  : b_req;
        cnt_inc    = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_ARB: begin
                cnt_d = '0;
                if (gnt_any && g_lock) begin
                    cnt_d   = CNT_W'(1);
                    state_d = g_side ? ST_LOCK_B : ST_LOCK_A;
                    if (other_req && (LOCK_MAX <= 1)) begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_LOCK_A, ST_LOCK_B: begin
                if (!own_req || !own_lock) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else if (peer_req) begin
                    if (cnt_inc >= CNT_MAX) begin
                        state_d = ST_ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; last=B so A wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= ST_ARB;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_side_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_side_q  <= rd_side_d;
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Testbench for ram_rr_arbiter: a RAM model, directed scenarios, and random traffic.
// Expectations come from a rule-level arbitration model and a shadow memory.
// They are queued at issue time and popped by an independent monitor.
module tb_ram_rr_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LM    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_lock, a_we, b_req, b_lock, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 37 + 11);
    endfunction

    // Single-port RAM with one-cycle read latency; contents survive arbiter reset.
    logic          ram_load = 1'b1;
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        int            side;   // -1 none, 0 A, 1 B
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct {
        int            side;
        logic [DW-1:0] data;
    } rexp_t;

    gexp_t         gnt_q[$];
    rexp_t         rd_q[$];
    int            glog[$];
    logic [DW-1:0] shadow [DEPTH];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] last_b_rdata = '0;

    // Reference model state: who holds the lock, how long the other side has waited, last winner.
    int m_owner  = -1;
    int m_streak = 0;
    int m_last   = 1;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_a(input logic r, input logic l, input logic w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_req = r; a_lock = l; a_we = w; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input logic r, input logic l, input logic w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_req = r; b_lock = l; b_we = w; b_addr = ad; b_wdata = d;
    endtask

    // Apply the current inputs for one cycle: predict, queue expectations, advance the clock.
    task automatic step(output int w);
        bit            rq[2];
        bit            lk[2];
        bit            wes[2];
        logic [AW-1:0] ads[2];
        logic [DW-1:0] wds[2];
        int            o;
        gexp_t         e;
        rexp_t         r;
        rq  = '{a_req, b_req};
        lk  = '{a_lock, b_lock};
        wes = '{a_we, b_we};
        ads = '{a_addr, b_addr};
        wds = '{a_wdata, b_wdata};
        w   = -1;
        if (rst) begin
            m_owner  = -1;
            m_streak = 0;
            m_last   = 1;
            rd_q.delete();
        end else begin
            if (m_owner >= 0)          w = rq[m_owner] ? m_owner : -1;
            else if (rq[0] && rq[1])   w = 1 - m_last;
            else if (rq[0])            w = 0;
            else if (rq[1])            w = 1;
            if (m_owner >= 0) begin
                o = m_owner;
                if (!rq[o] || !lk[o]) begin
                    m_owner = -1;
                end else if (rq[1 - o]) begin
                    m_streak++;
                    if (m_streak >= LM) m_owner = -1;
                end
            end else if (w >= 0 && lk[w]) begin
                m_owner  = w;
                m_streak = 1;
                if (rq[1 - w] && m_streak >= LM) m_owner = -1;
            end
            if (w >= 0) m_last = w;
        end
        e.side  = w;
        e.we    = (w >= 0) ? wes[w] : 1'b0;
        e.addr  = (w >= 0) ? ads[w] : '0;
        e.wdata = (w >= 0) ? wds[w] : '0;
        gnt_q.push_back(e);
        if (w >= 0) begin
            if (wes[w]) begin
                shadow[ads[w]] = wds[w];
            end else begin
                r.side = w;
                r.data = shadow[ads[w]];
                rd_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, "_len"}, glog.size() == exp.size(), glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) begin
            check($sformatf("%s_%0d", name, i), glog[i] == exp[i], glog[i], exp[i]);
        end
    endtask

    task automatic do_reset();
        int w;
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        rst = 1'b1;
        step(w);
        step(w);
        rst = 1'b0;
    endtask

    // Monitor: consumes one grant expectation per cycle and one read expectation per rvalid.
    always @(negedge clk) begin
        gexp_t e;
        rexp_t r;
        int    act;
        if (mon_en) begin
            if (gnt_q.size() == 0) begin
                check("gnt_queue_empty", 1'b0, 0, 1);
            end else begin
                e   = gnt_q.pop_front();
                act = a_gnt ? (b_gnt ? 2 : 0) : (b_gnt ? 1 : -1);
                glog.push_back(act);
                check("grant_side", act == e.side, act, e.side);
                check("ram_en", ram_en == (e.side >= 0), int'(ram_en), int'(e.side >= 0));
                check("ram_bus", {ram_we, ram_addr, ram_wdata} == {e.we, e.addr, e.wdata},
                      int'({ram_we, ram_addr, ram_wdata}), int'({e.we, e.addr, e.wdata}));
            end
            if (a_rvalid && b_rvalid) begin
                check("rvalid_both", 1'b0, 2, 1);
            end else if (a_rvalid || b_rvalid) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", 1'b0, int'(b_rvalid), -1);
                end else begin
                    r = rd_q.pop_front();
                    check("rvalid_side", int'(b_rvalid) == r.side, int'(b_rvalid), r.side);
                    check("rdata", (b_rvalid ? b_rdata : a_rdata) == r.data,
                          int'(b_rvalid ? b_rdata : a_rdata), int'(r.data));
                    check("rdata_idle_side", (b_rvalid ? a_rdata : b_rdata) == '0,
                          int'(b_rvalid ? a_rdata : b_rdata), 0);
                    if (b_rvalid) last_b_rdata = b_rdata;
                end
            end else begin
                check("rdata_zero", {a_rdata, b_rdata} == '0, int'({a_rdata, b_rdata}), 0);
            end
        end
    end

    initial begin
        int            w;
        bit            pend[2];
        bit            pwe[2];
        logic [AW-1:0] pad[2];
        logic [DW-1:0] pwd[2];
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
        rst = 1'b1;
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        @(posedge clk);
        #1;
        ram_load = 1'b0;
        mon_en   = 1'b1;

        // Reset with both sides requesting, then A wins the first cycle.
        glog.delete();
        set_a(1, 0, 0, 4'd3, '0);
        set_b(1, 0, 0, 4'd4, '0);
        rst = 1'b1;
        step(w);
        step(w);
        rst = 1'b0;
        step(w);
        check_log("reset_first", '{-1, -1, 0});
        do_reset();

        // Single read from A.
        glog.delete();
        set_a(1, 0, 0, 4'd3, '0);
        step(w);
        set_a(0, 0, 0, '0, '0);
        step(w);
        check_log("single_read", '{0, -1});

        // Contention: both hold reads, grants alternate starting with A.
        do_reset();
        glog.delete();
        set_a(1, 0, 0, 4'd1, '0);
        set_b(1, 0, 0, 4'd2, '0);
        repeat (6) step(w);
        check_log("contention", '{0, 1, 0, 1, 0, 1});
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        step(w);

        // Lock cap with B waiting: four A grants, then B.
        do_reset();
        glog.delete();
        set_a(1, 1, 0, 4'd7, '0);
        set_b(1, 0, 0, 4'd8, '0);
        repeat (5) step(w);
        check_log("lock_cap", '{0, 0, 0, 0, 1});
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        step(w);

        // Lock with B idle is unbounded; once B asks, the cap counts from the held value.
        do_reset();
        glog.delete();
        set_a(1, 1, 0, 4'd9, '0);
        repeat (10) step(w);
        check_log("lock_idle", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        glog.delete();
        set_b(1, 0, 0, 4'd10, '0);
        repeat (4) step(w);
        check_log("lock_then_b", '{0, 0, 0, 1});
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        step(w);

        // Reset squashes an in-flight read; write then read-back through B.
        do_reset();
        glog.delete();
        set_a(1, 0, 0, 4'd5, '0);
        step(w);
        set_a(0, 0, 0, '0, '0);
        rst = 1'b1;
        step(w);
        rst = 1'b0;
        set_a(1, 0, 1, 4'd5, 8'hAA);
        step(w);
        set_a(0, 0, 0, '0, '0);
        set_b(1, 0, 0, 4'd5, '0);
        step(w);
        set_b(0, 0, 0, '0, '0);
        step(w);
        check_log("midop_reset", '{0, -1, 0, 1, -1});
        check("b_readback_aa", last_b_rdata == 8'hAA, int'(last_b_rdata), 8'hAA);

        // Random traffic: held requests, withdrawals, locks, narrow addresses, rare resets.
        pend = '{0, 0};
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pend[s]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        pend[s] = 1'b1;
                        pwe[s]  = 1'($urandom_range(0, 1));
                        pad[s]  = AW'($urandom_range(0, 5));
                        pwd[s]  = DW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[s] = 1'b0;
                end
            end
            set_a(pend[0], pend[0] && ($urandom_range(0, 2) != 0), pwe[0], pad[0], pwd[0]);
            set_b(pend[1], pend[1] && ($urandom_range(0, 2) != 0), pwe[1], pad[1], pwd[1]);
            rst = ($urandom_range(0, 199) == 0);
            step(w);
            if (w >= 0) pend[w] = 1'b0;
        end
        rst = 1'b0;
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        step(w);
        step(w);

        check("gnt_queue_drained", gnt_q.size() == 0, gnt_q.size(), 0);
        check("rd_queue_drained", rd_q.size() == 0, rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
